// File: rtl/datamover_engine_if.sv
// HWPE-Stream style valid/ready link carrying a data word and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/datamover_engine.sv
// Datamover stage: buffers a length-counted load stream in a small register FIFO and replays it on the store side.
// Optional running XOR of emitted beats on checksum_o when DATAMOVER_ENGINE_CHECKSUM_EN is defined.
module datamover_engine #(
    parameter int unsigned BW         = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    hwpe_stream_intf_stream.slave   data_in,
    hwpe_stream_intf_stream.master  data_out,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        beat_cnt_o,
    output logic [BW-1:0]           checksum_o
);
    localparam int unsigned SW = BW / 8;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [BW-1:0]    mem_data_q [FIFO_DEPTH];
    logic [BW-1:0]    mem_data_d [FIFO_DEPTH];
    logic [SW-1:0]    mem_strb_q [FIFO_DEPTH];
    logic [SW-1:0]    mem_strb_d [FIFO_DEPTH];

    logic full, empty, in_ready, push, pop, start_ok;
    logic unused_test_mode;

    assign unused_test_mode = test_mode_i;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (occ_q == OW'(FIFO_DEPTH));
    assign empty    = (occ_q == '0);
    assign in_ready = (state_q == RUN) && enable_i && !full && (in_cnt_q < len_q);
    assign push     = data_in.valid && in_ready;
    assign pop      = !empty && data_out.ready;
    assign start_ok = (state_q == IDLE) && start_i;

    assign data_in.ready  = in_ready;
    assign data_out.valid = !empty;
    assign data_out.data  = mem_data_q[rd_ptr_q];
    assign data_out.strb  = mem_strb_q[rd_ptr_q];

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign beat_cnt_o = out_cnt_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        mem_data_d = mem_data_q;
        mem_strb_d = mem_strb_q;

        if (push) begin
            mem_data_d[wr_ptr_q] = data_in.data;
            mem_strb_d[wr_ptr_q] = data_in.strb;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
            in_cnt_d             = in_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d     = len_i;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (push && (in_cnt_q + CNT_W'(1) == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty && (out_cnt_q == len_q)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything, including a start in the same cycle.
        if (clear_i) begin
            state_d   = IDLE;
            len_d     = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_strb_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            mem_data_q <= mem_data_d;
            mem_strb_q <= mem_strb_d;
        end
    end

`ifdef DATAMOVER_ENGINE_CHECKSUM_EN
    logic [BW-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) checksum_d = '0;
        if (pop)      checksum_d = checksum_d ^ data_out.data;
        if (clear_i)  checksum_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) checksum_q <= '0;
        else         checksum_q <= checksum_d;
    end

    assign checksum_o = checksum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign checksum_o      = '0;
`endif
endmodule
